// File: rtl/mvm_pkg.sv
// Shared types and default dimensions for the 3x3 matrix-vector engine.
package mvm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;

    localparam int MVM_M       = 3;
    localparam int MVM_N       = 3;
    localparam int MVM_MAC_LAT = 2;

    // Address width for a memory of v entries, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mvm_sequencer_delay_line.sv
// Registered shift chain with synchronous clear.
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/mvm_sequencer.sv
// Pipelined issue engine for the matrix-vector engine: walks A/x row by
// row, drives the MAC strobes and schedules one y write per row.
module mvm_sequencer
    import mvm_pkg::*;
#(
    parameter int M       = MVM_M,
    parameter int N       = MVM_N,
    parameter int MAC_LAT = MVM_MAC_LAT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [clog2_min1(M*N)-1:0]   addr_a,
    output logic [clog2_min1(N)-1:0]     addr_x,
    output logic                         mac_valid,
    output logic                         mac_first,
    output logic                         wr_en_y,
    output logic [clog2_min1(M)-1:0]     addr_y
);

    localparam int LOGA = clog2_min1(M*N);
    localparam int LOGX = clog2_min1(N);
    localparam int LOGY = clog2_min1(M);

    localparam logic [LOGX-1:0] K_LAST = LOGX'(N-1);
    localparam logic [LOGY-1:0] R_LAST = LOGY'(M-1);

    seq_state_t      state;
    logic [LOGY-1:0] row;
    logic            issue;
    logic            first;
    logic            last;
    logic [LOGX-1:0] k_nxt;

    logic            mac_last;
    logic [LOGY-1:0] mac_row;
    logic            row_end;
    logic [LOGY-1:0] tag_row;

    assign k_nxt = (addr_x == K_LAST) ? '0 : addr_x + LOGX'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            issue  <= 1'b0;
            first  <= 1'b0;
            last   <= 1'b0;
            addr_a <= '0;
            addr_x <= '0;
            row    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        issue  <= 1'b1;
                        first  <= 1'b1;
                        last   <= (K_LAST == '0);
                        addr_a <= '0;
                        addr_x <= '0;
                        row    <= '0;
                    end
                end
                RUN: begin
                    if (addr_x == K_LAST && row == R_LAST) begin
                        state <= DRAIN;
                        issue <= 1'b0;
                        first <= 1'b0;
                        last  <= 1'b0;
                    end else begin
                        addr_a <= addr_a + LOGA'(1);
                        addr_x <= k_nxt;
                        if (addr_x == K_LAST) row <= row + LOGY'(1);
                        first <= (k_nxt == '0);
                        last  <= (k_nxt == K_LAST);
                    end
                end
                DRAIN: begin
                    // Earlier rows may still write here; only the last row ends the job.
                    if (wr_en_y && addr_y == R_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    delay_line #(
        .WIDTH (LOGY + 3),
        .DEPTH (1)
    ) u_mac_stage (
        .clk   (clk),
        .clear (reset),
        .d     ({issue, first, last, row}),
        .q     ({mac_valid, mac_first, mac_last, mac_row})
    );

    assign row_end = mac_valid & mac_last;
    assign tag_row = mac_row & {LOGY{row_end}};

    delay_line #(
        .WIDTH (LOGY + 1),
        .DEPTH (MAC_LAT)
    ) u_tag_stage (
        .clk   (clk),
        .clear (reset),
        .d     ({row_end, tag_row}),
        .q     ({wr_en_y, addr_y})
    );

endmodule

// File: tb/tb_mvm_sequencer.sv
// Self-checking bench: default (3,3,2) and non-square (2,4,3) sequencers
// against a cycle-offset job model, plus a small memory/MAC for row sums.
module tb_mvm_sequencer;

    typedef struct {
        int busy; int done; int a; int x;
        int mv; int mf; int wr; int ay;
    } exp_t;

    localparam int PM [2] = '{3, 2};
    localparam int PN [2] = '{3, 4};
    localparam int PL [2] = '{2, 3};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   cyc = 0;

    logic       a_busy, a_done, a_mv, a_mf, a_wr;
    logic [3:0] a_addr_a;
    logic [1:0] a_addr_x;
    logic [1:0] a_ay;

    logic       b_busy, b_done, b_mv, b_mf, b_wr;
    logic [2:0] b_addr_a;
    logic [1:0] b_addr_x;
    logic [0:0] b_ay;

    mvm_sequencer #(.M(3), .N(3), .MAC_LAT(2)) u_a (
        .clk(clk), .reset(reset), .start(start),
        .busy(a_busy), .done(a_done),
        .addr_a(a_addr_a), .addr_x(a_addr_x),
        .mac_valid(a_mv), .mac_first(a_mf),
        .wr_en_y(a_wr), .addr_y(a_ay)
    );

    mvm_sequencer #(.M(2), .N(4), .MAC_LAT(3)) u_b (
        .clk(clk), .reset(reset), .start(start),
        .busy(b_busy), .done(b_done),
        .addr_a(b_addr_a), .addr_x(b_addr_x),
        .mac_valid(b_mv), .mac_first(b_mf),
        .wr_en_y(b_wr), .addr_y(b_ay)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Expected outputs at cycle c for a job whose start was sampled at cycle s.
    function automatic exp_t model(input int s, input int c, input int m,
                                   input int n, input int l,
                                   input int ha, input int hx);
        exp_t e;
        int d;
        int total;
        e = '{default: 0};
        e.a = ha;
        e.x = hx;
        total = m * n;
        d = c - s;
        if (s < 0 || d < 1) return e;
        e.busy = (d <= total + 2 + l) ? 1 : 0;
        e.done = (d == total + 2 + l) ? 1 : 0;
        if (d <= total) begin
            e.a = d - 1;
            e.x = (d - 1) % n;
        end else begin
            e.a = total - 1;
            e.x = n - 1;
        end
        if (d >= 2 && d <= total + 1) begin
            e.mv = 1;
            e.mf = ((d - 2) % n == 0) ? 1 : 0;
        end
        for (int r = 0; r < m; r++) begin
            if (d == (r + 1) * n + 1 + l) begin
                e.wr = 1;
                e.ay = r;
            end
        end
        return e;
    endfunction

    function automatic exp_t actual(input int i);
        exp_t e;
        if (i == 0)
            e = '{int'(a_busy), int'(a_done), int'(a_addr_a), int'(a_addr_x),
                  int'(a_mv), int'(a_mf), int'(a_wr), int'(a_ay)};
        else
            e = '{int'(b_busy), int'(b_done), int'(b_addr_a), int'(b_addr_x),
                  int'(b_mv), int'(b_mf), int'(b_wr), int'(b_ay)};
        return e;
    endfunction

    int js [2] = '{-1, -1};
    int ha [2] = '{0, 0};
    int hx [2] = '{0, 0};
    bit mvalid = 0;

    bit rec_on = 0;
    int rec_base = 0;
    int wr_a [$];
    int wr_b [$];
    int done_a = -1;
    int done_b = -1;
    bit post_on = 0;
    int post_events = 0;

    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (mvalid) begin
            for (int i = 0; i < 2; i++) begin
                e = model(js[i], cyc, PM[i], PN[i], PL[i], ha[i], hx[i]);
                g = actual(i);
                chk($sformatf("busy%0d", i), g.busy, e.busy);
                chk($sformatf("done%0d", i), g.done, e.done);
                chk($sformatf("addr_a%0d", i), g.a, e.a);
                chk($sformatf("addr_x%0d", i), g.x, e.x);
                chk($sformatf("mac_valid%0d", i), g.mv, e.mv);
                if (e.mv != 0) chk($sformatf("mac_first%0d", i), g.mf, e.mf);
                chk($sformatf("wr_en_y%0d", i), g.wr, e.wr);
                if (e.wr != 0) chk($sformatf("addr_y%0d", i), g.ay, e.ay);
            end
        end
        if (rec_on) begin
            if (a_wr) wr_a.push_back(cyc - rec_base);
            if (b_wr) wr_b.push_back(cyc - rec_base);
            if (a_done) done_a = cyc - rec_base;
            if (b_done) done_b = cyc - rec_base;
        end
        if (post_on && (a_wr || b_wr || a_done || b_done || a_busy || b_busy))
            post_events++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                js[i] = -1;
                ha[i] = 0;
                hx[i] = 0;
            end else if (js[i] >= 0 && cyc - js[i] == PM[i] * PN[i] + 2 + PL[i]) begin
                js[i] = -1;
                ha[i] = PM[i] * PN[i] - 1;
                hx[i] = PN[i] - 1;
            end else if (js[i] < 0 && start) begin
                js[i] = cyc;
            end
        end
        if (reset) mvalid = 1;
    end

    // External A/x memories and MAC for the default instance.
    int a_mem [9] = '{1, -8, 3, 9, -5, 11, -7, 8, -9};
    int x_mem [3] = '{1, -22, 3};
    int a_q, x_q, acc, dout;
    int y_mem [3] = '{0, 0, 0};

    always @(posedge clk) begin
        a_q <= a_mem[a_addr_a];
        x_q <= x_mem[a_addr_x];
        if (a_mv) acc <= a_mf ? a_q * x_q : acc + a_q * x_q;
        dout <= acc;
        if (a_wr) y_mem[a_ay] <= dout;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(2);

        start = 1'b1;
        rec_base = cyc;
        rec_on = 1;
        tick(1);
        start = 1'b0;
        tick(20);
        rec_on = 0;
        chk("wr_count_a", wr_a.size(), 3);
        if (wr_a.size() == 3) begin
            chk("wr_a0", wr_a[0], 6);
            chk("wr_a1", wr_a[1], 9);
            chk("wr_a2", wr_a[2], 12);
        end
        chk("done_a", done_a, 13);
        chk("wr_count_b", wr_b.size(), 2);
        if (wr_b.size() == 2) begin
            chk("wr_b0", wr_b[0], 8);
            chk("wr_b1", wr_b[1], 12);
        end
        chk("done_b", done_b, 13);
        chk("y0", y_mem[0], 186);
        chk("y1", y_mem[1], 152);
        chk("y2", y_mem[2], -210);

        // Pulse start again exactly one cycle after done.
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(13);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(20);

        start = 1'b1;
        tick(45);
        start = 1'b0;
        tick(20);

        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        post_on = 1;
        tick(20);
        post_on = 0;
        chk("post_reset_quiet", post_events, 0);

        repeat (800) begin
            start = ($urandom_range(3) == 0);
            reset = ($urandom_range(99) == 0);
            tick(1);
        end
        start = 1'b0;
        reset = 1'b0;
        tick(25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvm_sequencer.md
# mvm_sequencer

Stand-alone schedule controller for the 3x3 matrix-vector engine. It replaces the state-3 address loop of the existing control logic with a parameterized, fully pipelined issue engine. After a `start` pulse it walks the A and x memories row by row, drives the MAC `mac_valid`/`mac_first` strobes, and writes each row result into the y/overflow memories. Loading the matrix and vector, and the output AXI handshake, stay outside this block.

## Interface

Parameters:
- `M`, 3: matrix rows (outputs), >=1
- `N`, 3: matrix columns (vector length), >=1
- `MAC_LAT`, 2: cycles from a row's last `mac_valid` to a stable sum on the MAC `d_out`, >=1

Derived widths: `LOGA = max(1,$clog2(M*N))`, `LOGX = max(1,$clog2(N))`, `LOGY = max(1,$clog2(M))`.

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin one multiply; sampled only in IDLE
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse at the end of the job
- `addr_a` out LOGA: A memory read address, row-major `r*N+k`
- `addr_x` out LOGX: x memory read address `k`
- `mac_valid` out 1: MAC operands are valid this cycle
- `mac_first` out 1: with `mac_valid`, k==0; MAC loads the product instead of accumulating
- `wr_en_y` out 1: write the MAC sum to y[`addr_y`]; also drives the overflow-memory write enable
- `addr_y` out LOGY: y/overflow write address (row index)

## Operation

- FSM states and transitions:
  - IDLE -> RUN when `start`=1.
  - RUN -> DRAIN after the issue with r=M-1, k=N-1.
  - DRAIN -> DONE on the cycle the last `wr_en_y` is asserted.
  - DONE -> IDLE unconditionally.
- RUN issues one (r,k) address pair per cycle with no bubbles, M*N cycles in total. k wraps N-1 -> 0 and r increments on the wrap.
- `addr_a` comes from an incrementing counter, not a multiplier. It holds its last value outside RUN.
- Memories have a 1-cycle registered read. `mac_valid` and `mac_first` are the issue strobe and the k==0 flag delayed by 1 cycle.
- A row-end tag (the k==N-1 flag plus r) travels with `mac_valid` and is delayed a further MAC_LAT cycles. On emergence it sets `wr_en_y`=1 and `addr_y`=r for exactly one cycle.
- Rows overlap: row r+1 products enter the MAC while row r drains. `mac_first` is the only accumulator reset, so no separate clear cycle is used.
- `start` in RUN, DRAIN or DONE is ignored; it is not queued.
- `reset` at any time: the next cycle is IDLE, every strobe is 0 and the in-flight pipeline tags are cleared. No late `wr_en_y` may appear.

## Timing

- Reset values: `busy`, `done`, `mac_valid`, `mac_first` and `wr_en_y` are 0. `addr_a`, `addr_x` and `addr_y` are 0.
- Cycle 0: `start` sampled in IDLE.
- Cycles 1..M*N: issue.
- Cycles 2..M*N+1: `mac_valid`.
- Row r write occurs at cycle `(r+1)*N + 1 + MAC_LAT`.
- `done` occurs at cycle `M*N + 2 + MAC_LAT`.
- IDLE resumes at the next cycle, where a new `start` is accepted.
- Defaults (3,3,2): writes at cycles 6, 9 and 12; `done` at 13; `busy` high for cycles 1..13.
- All outputs are registered. There are no combinational paths from `start` to any output.

## Structure

- Package `mvm_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t`
  - default dimension constants `MVM_M`, `MVM_N` and `MVM_MAC_LAT`, shared with the datapath and memories
- One sub-module, `delay_line #(WIDTH, DEPTH)`:
  - registered shift chain with synchronous clear
  - instantiated for the issue-to-MAC stage (depth 1)
  - instantiated for the row-end tag stage (depth MAC_LAT)
- Expected size: about 150-220 lines of RTL in total.

## Test plan

- **Defaults, single job:** `start` at cycle 0. Required:
  - `addr_a` reads 0..8 on cycles 1..9
  - `addr_x` repeats 0,1,2
  - `mac_first` at cycles 2, 5 and 8
  - `wr_en_y` at cycles 6, 9 and 12 with `addr_y` 0, 1, 2
  - `done` at cycle 13
- **End-to-end with `memory` and `part2_mac`:** load A = {1,-8,3,9,-5,11,-7,8,-9} and x = {1,-22,3}. Required: y = {186, 152, -210}, overflow = 0.
- **Back-to-back jobs:** assert `start` in the cycle after `done`. Required: second issue starts exactly 1 cycle later; no overlap or missing writes.
- **`start` held high through a whole job:** required: exactly one `done`, then an immediate restart from IDLE; no extra `wr_en_y` pulses.
- **Reset mid-DRAIN** (e.g. at cycle 10 of a default job): required: from cycle 11 `busy`=0 and no `wr_en_y` or `done` ever follows.
- **Non-square M=2, N=4, MAC_LAT=3:** required:
  - writes at cycles 8 and 12
  - `done` at 13
  - `addr_a` reads 0..7 on cycles 1..8
